// File: rtl/lane_hough_pkg.sv
// Shared types and constants for the lane Hough front end (edge point selection).
package lane_hough_pkg;

    localparam int unsigned COORD_W     = 12;
    localparam int unsigned XY_W        = 24;
    localparam int unsigned IMG_W_DEF   = 1280;
    localparam int unsigned IMG_H_DEF   = 720;
    localparam int unsigned NUM_PTS_DEF = 256;
    localparam int unsigned PT_CNT_W    = $clog2(NUM_PTS_DEF) + 1;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        COLLECT  = 2'd1,
        EMIT     = 2'd2
    } state_e;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    // Emitted point word: x in the upper half, y in the lower half.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } xy_t;

endpackage

// File: rtl/edge_point_sel_if.sv
// Pixel-stream input and point-burst output bundle of edge_point_sel.
interface edge_point_sel_if;
    import lane_hough_pkg::*;

    logic                frame_start;
    logic                pix_vld;
    logic                pix_edge;
    logic                interest_part;
    logic                out_vld;
    logic [XY_W-1:0]     x_y_axis;
    logic                part_o;
    logic [PT_CNT_W-1:0] pt_cnt;
    logic                frame_drop;

    modport master (
        output frame_start, pix_vld, pix_edge, interest_part,
        input  out_vld, x_y_axis, part_o, pt_cnt, frame_drop
    );

    modport slave (
        input  frame_start, pix_vld, pix_edge, interest_part,
        output out_vld, x_y_axis, part_o, pt_cnt, frame_drop
    );

endinterface

// File: rtl/edge_point_sel_pt_buf.sv
// Point buffer: simple dual-port RAM with registered read (1-cycle latency).
module pt_buf
    import lane_hough_pkg::*;
#(
    parameter  int unsigned DEPTH = NUM_PTS_DEF,
    parameter  int unsigned W     = XY_W,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    // Write-first forwarding: the first read of a burst can coincide with the final write.
    always_ff @(posedge clk) begin
        if (rd_en_i) rd_data_q <= (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/edge_point_sel.sv
// Collects lane-ROI edge pixels per frame, then emits a fixed NUM_PTS-word {x,y} burst.
// Optional per-line point cap is enabled by defining EDGE_ROW_LIMIT_EN.
module edge_point_sel
    import lane_hough_pkg::*;
#(
    parameter int unsigned IMG_W     = IMG_W_DEF,
    parameter int unsigned IMG_H     = IMG_H_DEF,
    parameter int unsigned ROI_Y_TOP = 360,
    parameter int unsigned X_SPLIT   = 640,
    parameter int unsigned NUM_PTS   = NUM_PTS_DEF
`ifdef EDGE_ROW_LIMIT_EN
   ,parameter int unsigned ROW_LIMIT = 4
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    edge_point_sel_if.slave bus_if
);

    localparam int unsigned AW = $clog2(NUM_PTS);
    localparam int unsigned CW = AW + 1;

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d, cur_x, cur_y;
    logic [CW-1:0]      wr_cnt_q, wr_cnt_d, wr_base, pt_cnt_q, pt_cnt_d, rd_nxt;
    logic [AW-1:0]      rd_cnt_q, rd_cnt_d, rd_addr;
    logic               part_q, part_d, part_o_q, part_o_d, side;
    logic               out_vld_q, out_vld_d, drop_q, drop_d;
    logic [XY_W-1:0]    xy_q, xy_d, rd_data;
    xy_t                wr_pt;
    logic               sof, last_x, last_y, cand, collecting, take, frame_done, rd_en;
`ifdef EDGE_ROW_LIMIT_EN
    localparam int unsigned RW = $clog2(ROW_LIMIT + 1);
    logic [RW-1:0]      row_cnt_q, row_cnt_d, row_base;
`endif

    // Current pixel position and candidate qualification; frame_start forces (0,0).
    always_comb begin
        sof        = bus_if.pix_vld && bus_if.frame_start;
        cur_x      = bus_if.frame_start ? '0 : x_cnt_q;
        cur_y      = bus_if.frame_start ? '0 : y_cnt_q;
        last_x     = (cur_x == COORD_W'(IMG_W - 1));
        last_y     = (cur_y == COORD_W'(IMG_H - 1));
        side       = sof ? bus_if.interest_part : part_q;
        cand       = bus_if.pix_vld && bus_if.pix_edge && (cur_y >= COORD_W'(ROI_Y_TOP)) &&
                     ((side == RIGHT) ? (cur_x >= COORD_W'(X_SPLIT)) : (cur_x < COORD_W'(X_SPLIT)));
        collecting = bus_if.pix_vld && ((state_q == COLLECT) || ((state_q == WAIT_SOF) && sof));
        wr_base    = sof ? '0 : wr_cnt_q;
        take       = collecting && cand && (wr_base < CW'(NUM_PTS));
`ifdef EDGE_ROW_LIMIT_EN
        row_base   = (cur_x == '0) ? '0 : row_cnt_q;
        take       = take && (row_base < RW'(ROW_LIMIT));
        row_cnt_d  = bus_if.pix_vld ? (row_base + RW'(take)) : row_cnt_q;
`endif
        frame_done = collecting && last_x && last_y;
        wr_pt.x    = cur_x;
        wr_pt.y    = cur_y;
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        x_cnt_d   = x_cnt_q;
        y_cnt_d   = y_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        pt_cnt_d  = pt_cnt_q;
        part_d    = part_q;
        part_o_d  = part_o_q;
        out_vld_d = 1'b0;
        drop_d    = 1'b0;
        xy_d      = xy_q;
        rd_en     = 1'b0;
        rd_addr   = '0;
        rd_nxt    = {1'b0, rd_cnt_q} + CW'(1);

        if (bus_if.pix_vld) begin
            x_cnt_d = last_x ? '0 : (cur_x + COORD_W'(1));
            y_cnt_d = !last_x ? cur_y : (last_y ? '0 : (cur_y + COORD_W'(1)));
        end

        case (state_q)
            WAIT_SOF, COLLECT: begin
                if (collecting) begin
                    wr_cnt_d = wr_base + CW'(take);
                    state_d  = COLLECT;
                    if (sof) part_d = bus_if.interest_part;
                end
                // Word 0 is fetched now so the burst starts two cycles after the last pixel.
                if (frame_done) begin
                    pt_cnt_d = wr_cnt_d;
                    rd_cnt_d = '0;
                    rd_en    = 1'b1;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                // Prefetch the next word; past the real points keep re-reading the last one.
                rd_en     = 1'b1;
                rd_addr   = ((pt_cnt_q != '0) && (rd_nxt >= pt_cnt_q)) ? AW'(pt_cnt_q - CW'(1))
                                                                        : rd_nxt[AW-1:0];
                out_vld_d = 1'b1;
                xy_d      = (pt_cnt_q == '0) ? '0 : rd_data;
                part_o_d  = part_q;
                drop_d    = sof;
                rd_cnt_d  = rd_cnt_q + AW'(1);
                if (rd_cnt_q == AW'(NUM_PTS - 1)) state_d = WAIT_SOF;
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= WAIT_SOF;
            x_cnt_q   <= '0;
            y_cnt_q   <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            pt_cnt_q  <= '0;
            part_q    <= 1'b0;
            part_o_q  <= 1'b0;
            out_vld_q <= 1'b0;
            drop_q    <= 1'b0;
            xy_q      <= '0;
`ifdef EDGE_ROW_LIMIT_EN
            row_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            x_cnt_q   <= x_cnt_d;
            y_cnt_q   <= y_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            pt_cnt_q  <= pt_cnt_d;
            part_q    <= part_d;
            part_o_q  <= part_o_d;
            out_vld_q <= out_vld_d;
            drop_q    <= drop_d;
            xy_q      <= xy_d;
`ifdef EDGE_ROW_LIMIT_EN
            row_cnt_q <= row_cnt_d;
`endif
        end
    end

    pt_buf #(
        .DEPTH (NUM_PTS),
        .W     (XY_W)
    ) u_pt_buf (
        .clk       (clk),
        .wr_en_i   (take),
        .wr_addr_i (wr_base[AW-1:0]),
        .wr_data_i (wr_pt),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign bus_if.out_vld    = out_vld_q;
    assign bus_if.x_y_axis   = xy_q;
    assign bus_if.part_o     = part_o_q;
    assign bus_if.pt_cnt     = PT_CNT_W'(pt_cnt_q);
    assign bus_if.frame_drop = drop_q;

endmodule

// File: tb/tb_edge_point_sel.sv
// Directed bench for edge_point_sel on a reduced 64x48 frame (ROI from line 24, split at x=32).
module tb_edge_point_sel;
    import lane_hough_pkg::*;

    localparam int unsigned W  = 64;
    localparam int unsigned H  = 48;
    localparam int unsigned RY = 24;
    localparam int unsigned XS = 32;
    localparam int unsigned NP = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    edge_point_sel_if bus_if();

    edge_point_sel #(
        .IMG_W     (W),
        .IMG_H     (H),
        .ROI_Y_TOP (RY),
        .X_SPLIT   (XS),
        .NUM_PTS   (NP)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus_if)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          first_cyc, last_cyc, last_pix_cyc, drop_cnt;
    int          nz, rep, bad;
    logic [23:0] q[$];
    logic [23:0] exp_w;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (bus_if.out_vld) begin
            if (q.size() == 0) first_cyc = cyc;
            last_cyc = cyc;
            q.push_back(bus_if.x_y_axis);
        end
        if (bus_if.frame_drop) drop_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic edge_at(input int mode, input int x, input int y);
        case (mode)
            1:       return (x == 10 && y == 30) || (x == 20 && y == 40) ||
                            (x == 50 && y == 40) || (x == 5 && y == 10);
            2:       return (x >= XS && y >= RY && ((y - RY) * (W - XS) + (x - XS)) < 300) ||
                            (x < 8 && y >= RY);
            3:       return (y == 30 && x < 10);
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle_inputs();
        bus_if.pix_vld       = 1'b0;
        bus_if.frame_start   = 1'b0;
        bus_if.pix_edge      = 1'b0;
        bus_if.interest_part = 1'b0;
    endtask

    task automatic send_frame(input int mode, input logic part, input bit with_sof);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                @(negedge clk);
                bus_if.pix_vld       = 1'b1;
                bus_if.frame_start   = with_sof && (x == 0) && (y == 0);
                bus_if.interest_part = part;
                bus_if.pix_edge      = edge_at(mode, x, y);
                last_pix_cyc         = cyc;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic wait_burst();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (q.size() >= NP) break;
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        drop_cnt = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_vld", bus_if.out_vld, 0);
        check_eq("rst_xy", bus_if.x_y_axis, 0);
        check_eq("rst_part", bus_if.part_o, 0);
        check_eq("rst_pt_cnt", bus_if.pt_cnt, 0);
        check_eq("rst_drop", bus_if.frame_drop, 0);
        rst_n = 1'b1;

        // Idle left frame: 256 zero words.
        q.delete();
        send_frame(0, 1'b0, 1'b1);
        wait_burst();
        nz = 0;
        foreach (q[i]) if (q[i] != 24'h0) nz++;
        check_eq("idle_len", q.size(), NP);
        check_eq("idle_nonzero", nz, 0);
        check_eq("idle_pt_cnt", bus_if.pt_cnt, 0);
        check_eq("idle_part", bus_if.part_o, 0);
        check_eq("idle_latency", first_cyc - last_pix_cyc, 2);
        check_eq("idle_contig", last_cyc - first_cyc, NP - 1);

        // Left frame: two real points then repeats of the last.
        q.delete();
        send_frame(1, 1'b0, 1'b1);
        wait_burst();
        rep = 0;
        for (int i = 1; i < q.size(); i++) if (q[i] == 24'h014028) rep++;
        check_eq("left_len", q.size(), NP);
        check_eq("left_w0", q[0], 24'h00A01E);
        check_eq("left_w1", q[1], 24'h014028);
        check_eq("left_repeats", rep, NP - 1);
        check_eq("left_pt_cnt", bus_if.pt_cnt, 2);
        check_eq("left_part", bus_if.part_o, 0);
        check_eq("left_hold_vld", bus_if.out_vld, 0);
        check_eq("left_hold_xy", bus_if.x_y_axis, 24'h014028);

        // Right frame with 300 candidates: first 256 in raster order.
        q.delete();
        send_frame(2, 1'b1, 1'b1);
        wait_burst();
        bad = 0;
        for (int k = 0; k < q.size(); k++) begin
            exp_w = {12'(XS + k % (W - XS)), 12'(RY + k / (W - XS))};
            if (q[k] != exp_w) bad++;
        end
        check_eq("right_len", q.size(), NP);
        check_eq("right_words_bad", bad, 0);
        check_eq("right_w0", q[0], 24'h020018);
        check_eq("right_w255", q[255], 24'h03F01F);
        check_eq("right_pt_cnt", bus_if.pt_cnt, 256);
        check_eq("right_part", bus_if.part_o, 1);
        check_eq("right_latency", first_cyc - last_pix_cyc, 2);

        // frame_start 10 cycles into EMIT: that frame is dropped.
        q.delete();
        drop_cnt = 0;
        send_frame(1, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        send_frame(2, 1'b1, 1'b1);
        repeat (300) @(negedge clk);
        check_eq("drop_pulses", drop_cnt, 1);
        check_eq("drop_len", q.size(), NP);
        check_eq("drop_w1", q[1], 24'h014028);
        check_eq("drop_w255", q[255], 24'h014028);
        check_eq("drop_pt_cnt", bus_if.pt_cnt, 2);
        check_eq("drop_part", bus_if.part_o, 0);
        q.delete();
        send_frame(2, 1'b1, 1'b1);
        wait_burst();
        check_eq("after_drop_len", q.size(), NP);
        check_eq("after_drop_w0", q[0], 24'h020018);
        check_eq("after_drop_part", bus_if.part_o, 1);

        // Synchronous reset at burst index 100.
        q.delete();
        send_frame(1, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (q.size() >= 100) break;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_mid_vld", bus_if.out_vld, 0);
        check_eq("rst_mid_xy", bus_if.x_y_axis, 0);
        check_eq("rst_mid_pt_cnt", bus_if.pt_cnt, 0);
        check_eq("rst_mid_part", bus_if.part_o, 0);
        repeat (300) @(negedge clk);
        check_eq("rst_mid_len", q.size(), 100);
        // Without frame_start the block stays idle.
        send_frame(1, 1'b0, 1'b0);
        repeat (300) @(negedge clk);
        check_eq("rst_wait_sof_len", q.size(), 100);

        // Ten left edges on one line.
        q.delete();
        send_frame(3, 1'b0, 1'b1);
        wait_burst();
        check_eq("row_len", q.size(), NP);
        check_eq("row_w0", q[0], 24'h00001E);
        check_eq("row_w3", q[3], 24'h00301E);
`ifdef EDGE_ROW_LIMIT_EN
        check_eq("row_pt_cnt", bus_if.pt_cnt, 4);
        check_eq("row_w4", q[4], 24'h00301E);
`else
        check_eq("row_pt_cnt", bus_if.pt_cnt, 10);
        check_eq("row_w4", q[4], 24'h00401E);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
